// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM port arbiter shared by IF and MEM, MEM has priority
module mem_ctrl #(
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_done_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [1:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_done_o,
  output logic [31:0] ram_addr_o,
  output logic        ram_we_o,
  output logic [7:0]  ram_wdata_o,
  input  logic [7:0]  ram_rdata_i
);
  localparam logic [2:0] LAT = 3'(READ_LATENCY);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t      state;
  logic        own_mem;
  logic [31:0] addr, wdata, rbuf, rnext;
  logic [2:0]  n, cnt, nxt;
  logic [1:0]  idx;
  assign nxt = cnt + 3'd1;
  assign idx = 2'(cnt - LAT);
  // read buffer with the byte arriving this cycle merged in (byte k lands LAT cycles after its address)
  always_comb begin
    rnext = rbuf;
    if (cnt >= LAT) rnext[8*idx +: 8] = ram_rdata_i;
  end
  // arbitration, byte sequencing and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      own_mem     <= 1'b0;
      addr        <= '0;
      wdata       <= '0;
      rbuf        <= '0;
      n           <= '0;
      cnt         <= '0;
      if_data_o   <= '0;
      if_done_o   <= 1'b0;
      mem_rdata_o <= '0;
      mem_done_o  <= 1'b0;
      ram_addr_o  <= '0;
      ram_we_o    <= 1'b0;
      ram_wdata_o <= '0;
    end else begin
      if_done_o  <= 1'b0;
      mem_done_o <= 1'b0;
      case (state)
        IDLE: begin
          cnt  <= '0;
          rbuf <= '0;
          if (mem_req_i) begin
            own_mem <= 1'b1;
            addr    <= mem_addr_i;
            wdata   <= mem_wdata_i;
            n       <= mem_sel_i == 2'b01 ? 3'd1 : mem_sel_i == 2'b10 ? 3'd2 : 3'd4;
            if (mem_sel_i == 2'b00) begin
              state       <= DONE;
              mem_done_o  <= 1'b1;
              mem_rdata_o <= '0;
            end else if (mem_we_i) begin
              state       <= WRITE;
              ram_we_o    <= 1'b1;
              ram_addr_o  <= mem_addr_i;
              ram_wdata_o <= mem_wdata_i[7:0];
            end else begin
              state      <= READ;
              ram_addr_o <= mem_addr_i;
            end
          end else if (if_req_i) begin
            own_mem    <= 1'b0;
            addr       <= if_addr_i;
            n          <= 3'd4;
            state      <= READ;
            ram_addr_o <= if_addr_i;
          end
        end
        READ: begin
          cnt        <= nxt;
          rbuf       <= rnext;
          ram_addr_o <= nxt < n ? addr + 32'(nxt) : '0;
          if (nxt == n + LAT) begin
            state <= DONE;
            if (own_mem) begin
              mem_done_o  <= 1'b1;
              mem_rdata_o <= rnext;
            end else begin
              if_done_o <= 1'b1;
              if_data_o <= rnext;
            end
          end
        end
        WRITE: begin
          cnt <= nxt;
          if (nxt < n) begin
            ram_addr_o  <= addr + 32'(nxt);
            ram_wdata_o <= wdata[8*nxt[1:0] +: 8];
          end else begin
            state       <= DONE;
            ram_we_o    <= 1'b0;
            ram_addr_o  <= '0;
            ram_wdata_o <= '0;
            mem_done_o  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed stimulus with a transaction-level model checked every cycle
module tb_mem_ctrl;
  localparam int LAT = 2;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i, mem_req_i, mem_we_i;
  logic [1:0]  mem_sel_i;
  logic [31:0] if_addr_i, mem_addr_i, mem_wdata_i;
  logic [31:0] if_data_o, mem_rdata_o, ram_addr_o;
  logic        if_done_o, mem_done_o, ram_we_o;
  logic [7:0]  ram_wdata_o, ram_rdata_i;

  mem_ctrl #(.READ_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_done_o(if_done_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o),
    .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at cycle %0d", nm, got, exp, cyc);
  endtask

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      12'h100: return 8'h13;
      12'h101: return 8'h05;
      12'h022: return 8'h77;
      12'h031: return 8'h80;
      12'h043: return 8'h5A;
      default: return 8'h00;
    endcase
  endfunction

  // RAM: 4 KiB image indexed by the low address bits, read data appears LAT cycles after the address
  logic [7:0]  ram [0:4095];
  logic [31:0] a1, a2;
  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = init_byte(i);
    a1 = '0;
    a2 = '0;
    ram_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (ram_we_o === 1'b1) ram[ram_addr_o[11:0]] = ram_wdata_o;
      ram_rdata_i = ram[a2[11:0]];
      a2 = a1;
      a1 = ram_addr_o;
    end
  end

  // transaction-level model: one active transfer with its RAM window and done cycle
  int          cyc = 0;
  bit          armed = 0, busy = 0, t_mem = 0, t_we = 0;
  int          s = 0, n = 0, d = 0;
  logic [31:0] t_addr = '0, t_wd = '0, t_val = '0, m_if = '0, m_mem = '0;
  logic [7:0]  ref_mem [0:4095];

  function automatic logic [31:0] word_at(input logic [31:0] a, input int nn);
    logic [31:0] v = '0;
    for (int k = 0; k < nn; k++) v |= 32'(ref_mem[12'(a + 32'(k))]) << (8 * k);
    return v;
  endfunction

  task automatic bus(output logic [31:0] ea, output logic ew, output logic [7:0] ed);
    int  k = cyc - s;
    bit  act = busy && k >= 0 && k < n;
    ea = act ? t_addr + 32'(k) : '0;
    ew = act && t_we;
    ed = ew ? t_wd[8*k +: 8] : '0;
  endtask

  initial begin
    logic [31:0] ea;
    logic        ew;
    logic [7:0]  ed;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_byte(i);
    forever begin
      @(posedge clk);
      bus(ea, ew, ed);
      if (ew) ref_mem[ea[11:0]] = ed;
      if (!rst) begin
        busy  = 0;
        m_if  = '0;
        m_mem = '0;
        armed = 1;
      end else if (busy) begin
        if (cyc + 1 == d) begin
          if (!t_mem) m_if = t_val;
          else if (!t_we) m_mem = t_val;
        end
        if (cyc == d) busy = 0;
      end else if (mem_req_i || if_req_i) begin
        busy   = 1;
        s      = cyc + 1;
        t_mem  = mem_req_i;
        t_addr = mem_req_i ? mem_addr_i : if_addr_i;
        n      = !mem_req_i ? 4 : mem_sel_i == 2'd1 ? 1 : mem_sel_i == 2'd2 ? 2 : mem_sel_i == 2'd3 ? 4 : 0;
        t_we   = mem_req_i && mem_we_i && n > 0;
        t_wd   = mem_wdata_i;
        t_val  = word_at(t_addr, n);
        d      = n == 0 ? cyc + 1 : t_we ? cyc + 1 + n : cyc + 1 + n + LAT;
        if (d == cyc + 1) m_mem = '0;
      end
      cyc++;
    end
  end

  // every-cycle comparison of all outputs against the model
  initial begin
    logic [31:0] ea;
    logic        ew;
    logic [7:0]  ed;
    forever begin
      @(negedge clk);
      if (armed) begin
        bus(ea, ew, ed);
        chk("ram_addr", ram_addr_o, ea);
        chk("ram_we", 32'(ram_we_o), 32'(ew));
        chk("ram_wdata", 32'(ram_wdata_o), 32'(ed));
        chk("if_done", 32'(if_done_o), 32'(busy && cyc == d && !t_mem));
        chk("mem_done", 32'(mem_done_o), 32'(busy && cyc == d && t_mem));
        chk("if_data", if_data_o, m_if);
        chk("mem_rdata", mem_rdata_o, m_mem);
      end
    end
  end

  int we_cnt = 0;
  initial forever begin
    @(negedge clk);
    if (ram_we_o === 1'b1) we_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_go(input logic we, input logic [1:0] sel, input logic [31:0] a,
                        input logic [31:0] wd, output int c);
    tick();
    mem_we_i    = we;
    mem_sel_i   = sel;
    mem_addr_i  = a;
    mem_wdata_i = wd;
    mem_req_i   = 1'b1;
    c = cyc;
  endtask

  task automatic wait_done(input bit is_mem, input string nm, output int at);
    at = -1;
    for (int i = 0; i < 24 && at < 0; i++) begin
      @(negedge clk);
      if ((is_mem ? mem_done_o : if_done_o) === 1'b1) at = cyc;
    end
    if (at < 0) begin
      total++;
      $display("FAIL %s_timeout: no done pulse within 24 cycles", nm);
    end
    if (is_mem) mem_req_i = 1'b0;
    else if_req_i = 1'b0;
  endtask

  initial begin
    int c, at, cnt;
    rst = 1'b0;
    if_req_i = 1'b1;
    mem_req_i = 1'b1;
    mem_we_i = 1'b1;
    mem_sel_i = 2'b11;
    mem_addr_i = 32'h40;
    mem_wdata_i = 32'hFFFFFFFF;
    if_addr_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    if_req_i = 1'b0;
    mem_req_i = 1'b0;
    @(negedge clk);
    chk("rst_ram_we", 32'(ram_we_o), 0);
    chk("rst_ram_addr", ram_addr_o, 0);
    chk("rst_if_data", if_data_o, 0);
    chk("rst_no_write", 32'(ram[12'h040]), 0);

    tick();
    if_addr_i = 32'h100;
    if_req_i = 1'b1;
    c = cyc;
    @(negedge clk);
    @(negedge clk);
    chk("if_first_addr", ram_addr_o, 32'h100);
    wait_done(0, "if_fetch", at);
    chk("if_fetch_lat", 32'(at - c), 7);
    chk("if_fetch_data", if_data_o, 32'h00000513);

    we_cnt = 0;
    mem_go(1, 2'b10, 32'h20, 32'hAABBCCDD, c);
    wait_done(1, "half_store", at);
    chk("half_store_lat", 32'(at - c), 3);
    chk("half_store_we_cycles", 32'(we_cnt), 2);
    chk("half_store_b0", 32'(ram[12'h020]), 32'hDD);
    chk("half_store_b1", 32'(ram[12'h021]), 32'hCC);
    chk("half_store_b2_kept", 32'(ram[12'h022]), 32'h77);

    mem_go(0, 2'b01, 32'h31, 32'h0, c);
    wait_done(1, "byte_load", at);
    chk("byte_load_lat", 32'(at - c), 4);
    chk("byte_load_data", mem_rdata_o, 32'h00000080);

    mem_go(0, 2'b11, 32'h100, 32'h0, c);
    if_addr_i = 32'h20;
    if_req_i = 1'b1;
    wait_done(1, "arb_mem", at);
    chk("arb_mem_lat", 32'(at - c), 7);
    chk("arb_mem_data", mem_rdata_o, 32'h00000513);
    wait_done(0, "arb_if", at);
    chk("arb_if_lat", 32'(at - c), 15);
    chk("arb_if_data", if_data_o, 32'h0077CCDD);

    mem_go(1, 2'b11, 32'hFFFFFFFE, 32'hDEADBEEF, c);
    wait_done(1, "wrap_store", at);
    chk("wrap_store_lat", 32'(at - c), 5);
    chk("wrap_b_fff", 32'(ram[12'hFFF]), 32'hBE);
    chk("wrap_b_000", 32'(ram[12'h000]), 32'hAD);
    mem_go(0, 2'b11, 32'hFFFFFFFE, 32'h0, c);
    wait_done(1, "wrap_load", at);
    chk("wrap_load_lat", 32'(at - c), 7);
    chk("wrap_load_data", mem_rdata_o, 32'hDEADBEEF);

    mem_go(0, 2'b10, 32'h20, 32'h0, c);
    wait_done(1, "half_load", at);
    chk("half_load_lat", 32'(at - c), 5);
    chk("half_load_data", mem_rdata_o, 32'h0000CCDD);

    mem_go(0, 2'b00, 32'h80, 32'h0, c);
    wait_done(1, "nop", at);
    chk("nop_lat", 32'(at - c), 1);
    chk("nop_data", mem_rdata_o, 32'h0);

    mem_go(1, 2'b11, 32'h40, 32'h11223344, c);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    mem_req_i = 1'b0;
    @(negedge clk);
    chk("abort_we_off", 32'(ram_we_o), 0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_done_o === 1'b1) cnt++;
    end
    chk("abort_no_done", 32'(cnt), 0);
    chk("abort_b0", 32'(ram[12'h040]), 32'h44);
    chk("abort_b2", 32'(ram[12'h042]), 32'h22);
    chk("abort_b3_kept", 32'(ram[12'h043]), 32'h5A);

    repeat (2) tick();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
